// File: rtl/adc32_seq_ctrl_pkg.sv
// rtl/adc32_seq_ctrl_pkg.sv - shared types and width helpers for the sequential adder controller
package adc32_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;

  // Operands are consumed one nibble per step, so the width must split into at least two nibbles.
  function automatic bit width_ok(input int unsigned w);
    return ((w % 4) == 0) && (w >= 8);
  endfunction

  function automatic int unsigned nib_count(input int unsigned w);
    return w / 4;
  endfunction

endpackage

// File: rtl/adc32_seq_ctrl_if.sv
// rtl/adc32_seq_ctrl_if.sv - start/busy/done operand and result bundle
interface adc32_seq_ctrl_if
  import adc32_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, co, ovf
  );

endinterface

// File: rtl/adc32_seq_ctrl_add4b.sv
// rtl/adc32_seq_ctrl_add4b.sv - 4-bit carry-lookahead slice with group generate/propagate
module add4b (
  input  logic       C0,
  input  logic [3:0] ai,
  input  logic [3:0] bi,
  output logic [3:0] s,
  output logic       GG,
  output logic       GP
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = ai & bi;
  assign p = ai ^ bi;

  assign c[0] = C0;
  assign c[1] = g[0] | (p[0] & C0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C0);

  assign s  = p ^ c;
  assign GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign GP = &p;

endmodule

// File: rtl/adc32_seq_ctrl.sv
// rtl/adc32_seq_ctrl.sv - nibble-serial add/subtract controller around a single add4b slice
module adc32_seq_ctrl
  import adc32_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic              clk,
  input logic              rst,
  adc32_seq_ctrl_if.slave  bus
);

  localparam int NIB = nib_count(WIDTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW  = KW + 2;

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("adc32_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] s_r;
  logic             co_r;
  logic             ovf_r;

  logic [BW-1:0]    bit_idx;
  logic [3:0]       slice_s;
  logic             gg;
  logic             gp;
  logic             nib_co;
  logic             last;

  assign bit_idx = {k, 2'b00};
  assign nib_co  = gg | (gp & carry_r);
  assign last    = (k == KW'(NIB - 1));

  add4b u_slice (
    .C0 (carry_r),
    .ai (a_r[bit_idx +: 4]),
    .bi (b_r[bit_idx +: 4]),
    .s  (slice_s),
    .GG (gg),
    .GP (gp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction reuses the adder: b is inverted at latch time and the carry-in forced high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      k       <= '0;
      s_r     <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b ^ {WIDTH{bus.sub}};
            carry_r <= bus.sub | bus.cin;
            k       <= '0;
            s_r     <= '0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          s_r[bit_idx +: 4] <= slice_s;
          carry_r           <= nib_co;
          k                 <= k + KW'(1);
          if (last) begin
            co_r  <= nib_co;
            ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (slice_s[3] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.s    = s_r;
  assign bus.co   = co_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_adc32_seq_ctrl.sv
// tb/tb_adc32_seq_ctrl.sv - directed and random scoreboard bench for adc32_seq_ctrl
module tb_adc32_seq_ctrl;
  import adc32_seq_ctrl_pkg::*;

  localparam int W   = 32;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc32_seq_ctrl_if #(.WIDTH(W)) bus ();

  adc32_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb    = sub ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r.s   = t[W-1:0];
    r.co  = t[W];
    r.ovf = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Returns one cycle after the start edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    bus.start = 1'b1;
    sb.push_back(e);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit check_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 4 * NIB) begin
      step();
      lat++;
    end
    check({tag, "_done_seen"}, bus.done, 1);
    if (bus.done === 1'b1) begin
      if (check_lat) check({tag, "_latency"}, lat, NIB + 1);
      check({tag, "_sb_depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_s"}, bus.s, e.s);
        check({tag, "_co"}, bus.co, e.co);
        check({tag, "_ovf"}, bus.ovf, e.ovf);
      end
    end
    step();
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_s_hold"}, bus.s, (sb.size() == 0 && e.s !== 'x) ? e.s : bus.s);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done === 1'b1) n++;
      step();
    end
  endtask

  initial begin
    int          extra;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst       = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_s", bus.s, 0);
    check("rst_co", bus.co, 0);
    check("rst_ovf", bus.ovf, 0);

    launch(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, '{s: 32'h0000_0000, co: 1'b1, ovf: 1'b0});
    check("wrap_busy_run", bus.busy, 1);
    check("wrap_s_cleared", bus.s, 0);
    wait_done("wrap", 1'b1);

    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{s: 32'h8000_0000, co: 1'b0, ovf: 1'b1});
    wait_done("pos_ovf", 1'b1);

    launch(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{s: 32'hFFFF_FFFE, co: 1'b0, ovf: 1'b0});
    wait_done("sub_borrow", 1'b1);

    launch(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{s: 32'h7FFF_FFFF, co: 1'b1, ovf: 1'b1});
    wait_done("sub_ovf", 1'b1);

    launch(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, '{s: 32'h0000_0007, co: 1'b0, ovf: 1'b0});
    step();
    step();
    bus.a     = 32'h0000_00FF;
    bus.b     = 32'h0000_00FF;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("ign_start", 1'b0);
    count_dones(3 * NIB, extra);
    check("ign_extra_done", extra, 0);

    launch(32'h0000_AAAA, 32'h0000_5555, 1'b0, 1'b0, '{s: 32'h0000_FFFF, co: 1'b0, ovf: 1'b0});
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_s", bus.s, 0);
    check("abort_co", bus.co, 0);
    check("abort_ovf", bus.ovf, 0);
    count_dones(3 * NIB, extra);
    check("abort_no_done", extra, 0);

    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{s: 32'h2345_6789, co: 1'b0, ovf: 1'b0});
    wait_done("post_abort", 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      launch(ra, rb, rc, rs, model(ra, rb, rc, rs));
      wait_done($sformatf("rnd%0d", i), 1'b1);
    end

    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
